// File: rtl/ibex_register_file_mp.sv
// Multi-port register file with hardwired x0, reset-free storage and a scrub FSM that zeroes it.
// Optional same-cycle write-to-read bypass is enabled by defining IBEX_RF_WRITE_BYPASS_EN.
module ibex_register_file_mp #(
  parameter bit RV32E         = 1'b0,
  parameter int DataWidth     = 32,
  parameter int NumReadPorts  = 2,
  parameter int NumWritePorts = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               test_en_i,
  input  logic                               scrub_req_i,
  output logic                               ready_o,
  input  logic [NumReadPorts*5-1:0]          raddr_i,
  output logic [NumReadPorts*DataWidth-1:0]  rdata_o,
  input  logic [NumWritePorts*5-1:0]         waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]           we_i,
  output logic                               wr_collide_o
);

  localparam int NumWords = RV32E ? 16 : 32;
  localparam int AddrW    = RV32E ? 4 : 5;
  localparam logic [AddrW-1:0] CntOne  = {{(AddrW-1){1'b0}}, 1'b1};
  localparam logic [AddrW-1:0] CntLast = {AddrW{1'b1}};
  localparam logic [AddrW-1:0] IdxZero = {AddrW{1'b0}};

  if (NumReadPorts < 1 || NumReadPorts > 4) begin : gen_bad_read_ports
    $error("ibex_register_file_mp: NumReadPorts must be in 1..4");
  end
  if (NumWritePorts < 1 || NumWritePorts > 2) begin : gen_bad_write_ports
    $error("ibex_register_file_mp: NumWritePorts must be in 1..2");
  end

  typedef enum logic {SCRUB = 1'b0, READY = 1'b1} state_e;

  state_e            state;
  state_e            state_next;
  logic [AddrW-1:0]  scrub_cnt;
  logic [AddrW-1:0]  scrub_cnt_next;
  logic [DataWidth-1:0] mem [NumWords];
  logic [AddrW-1:0]  ridx [NumReadPorts];
  logic [AddrW-1:0]  widx [NumWritePorts];
  logic [NumWritePorts-1:0] wact;
  logic              unused_inputs;

  // Bit 4 of every address is dropped in RV32E, so x16..x31 alias onto x0..x15.
  assign unused_inputs = test_en_i ^ (^raddr_i) ^ (^waddr_i);
  assign ready_o       = (state == READY);

  // Decode register indices and qualify write ports (x0 and scrub suppress writes).
  always_comb begin
    for (int p = 0; p < NumReadPorts; p++) begin
      ridx[p] = raddr_i[5*p +: AddrW];
    end
    for (int w = 0; w < NumWritePorts; w++) begin
      widx[w] = waddr_i[5*w +: AddrW];
      wact[w] = we_i[w] && (widx[w] != IdxZero) && (state == READY);
    end
  end

  // Scrub FSM next-state logic.
  always_comb begin
    state_next     = state;
    scrub_cnt_next = scrub_cnt;
    case (state)
      SCRUB: begin
        scrub_cnt_next = scrub_cnt + CntOne;
        if (scrub_cnt == CntLast) begin
          state_next = READY;
        end else begin
          state_next = SCRUB;
        end
      end
      READY: begin
        if (scrub_req_i) begin
          state_next     = SCRUB;
          scrub_cnt_next = CntOne;
        end else begin
          state_next     = READY;
        end
      end
      default: begin
        state_next     = SCRUB;
        scrub_cnt_next = CntOne;
      end
    endcase
  end

  // Scrub FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= SCRUB;
      scrub_cnt <= CntOne;
    end else begin
      state     <= state_next;
      scrub_cnt <= scrub_cnt_next;
    end
  end

  // Storage: no reset; scrub zeroes it, later ports override earlier ones on the same index.
  always_ff @(posedge clk_i) begin
    if (state == SCRUB) begin
      mem[scrub_cnt] <= {DataWidth{1'b0}};
    end else begin
      for (int w = 0; w < NumWritePorts; w++) begin
        if (wact[w]) begin
          mem[widx[w]] <= wdata_i[DataWidth*w +: DataWidth];
        end
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    rdata_o = {(NumReadPorts*DataWidth){1'b0}};
    for (int p = 0; p < NumReadPorts; p++) begin
      if ((state == READY) && (ridx[p] != IdxZero)) begin
        rdata_o[DataWidth*p +: DataWidth] = mem[ridx[p]];
`ifdef IBEX_RF_WRITE_BYPASS_EN
        for (int w = 0; w < NumWritePorts; w++) begin
          if (wact[w] && (widx[w] == ridx[p])) begin
            rdata_o[DataWidth*p +: DataWidth] = wdata_i[DataWidth*w +: DataWidth];
          end else begin
            rdata_o[DataWidth*p +: DataWidth] = rdata_o[DataWidth*p +: DataWidth];
          end
        end
`endif
      end else begin
        rdata_o[DataWidth*p +: DataWidth] = {DataWidth{1'b0}};
      end
    end
  end

  // Same-index write collision flag (wact already excludes x0 and scrub).
  always_comb begin
    wr_collide_o = 1'b0;
    for (int i = 0; i < NumWritePorts; i++) begin
      for (int j = i + 1; j < NumWritePorts; j++) begin
        wr_collide_o = wr_collide_o | (wact[i] & wact[j] & (widx[i] == widx[j]));
      end
    end
  end

endmodule
